// File: rtl/kesme_denetleyici_pkg.sv
// Shared constants for the machine-level interrupt scheduler:
// mcause values, mip/mie bit positions and the scheduler states.
package kesme_denetleyici_pkg;

    localparam logic [31:0] KESME_MEI = 32'h8000_000B;
    localparam logic [31:0] KESME_MSI = 32'h8000_0003;
    localparam logic [31:0] KESME_MTI = 32'h8000_0007;

    localparam int unsigned MIP_MEI = 11;
    localparam int unsigned MIP_MSI = 3;
    localparam int unsigned MIP_MTI = 7;

    typedef enum logic [1:0] {
        KD_BOSTA   = 2'd0,
        KD_BEKLE   = 2'd1,
        KD_TETIKLE = 2'd2,
        KD_ISLE    = 2'd3
    } kd_durum_t;

    // Priority rank of a cause value; higher wins, 0 means no cause.
    function automatic logic [1:0] neden_derece(input logic [31:0] neden);
        case (neden)
            KESME_MEI: neden_derece = 2'd3;
            KESME_MSI: neden_derece = 2'd2;
            KESME_MTI: neden_derece = 2'd1;
            default:   neden_derece = 2'd0;
        endcase
    endfunction

endpackage

// File: rtl/kesme_denetleyici_oncelik_secici.sv
// Fixed-priority selector: external > software > timer.
module kesme_oncelik_secici
    import kesme_denetleyici_pkg::*;
(
    input  logic [2:0]  i_uygun,   // {ext, sw, timer} eligible bits
    output logic        o_var,
    output logic [31:0] o_neden
);

    // Pick the highest-priority eligible source and its mcause value.
    always_comb begin
        o_var   = |i_uygun;
        o_neden = '0;
        if (i_uygun[2])      o_neden = KESME_MEI;
        else if (i_uygun[1]) o_neden = KESME_MSI;
        else if (i_uygun[0]) o_neden = KESME_MTI;
    end

endmodule

// File: rtl/kesme_denetleyici.sv
// Machine-level interrupt scheduler between the interrupt sources and the
// CSR unit. Arbitrates, stalls fetch until the pipeline drains, then issues
// a one-cycle trap request and blocks further interrupts until MRET.
// Optional: KESME_ESZAMANLAYICI_EN adds a 2-flop synchronizer on kesme_g.
module kesme_denetleyici
    import kesme_denetleyici_pkg::*;
#(
    parameter int unsigned BEKLEME_SINIR = 64
) (
    input  logic        clk_g,
    input  logic        rst_g,
    input  logic        kesme_g,
    input  logic        yazilim_kesme_g,
    input  logic        zamanlayici_kesme_g,
    input  logic        mstatus_mie_g,
    input  logic [31:0] mie_g,
    input  logic        boru_bos_g,
    input  logic        odd_mesgul_g,
    input  logic        mret_g,
    input  logic [31:0] siradaki_ps_g,
    output logic        getir_durdur_c,
    output logic        kesme_gecerli_c,
    output logic [31:0] kesme_kod_c,
    output logic [31:0] kesme_ps_c,
    output logic [31:0] mip_c,
    output logic        zaman_asimi_c
);

    localparam int unsigned SW = $clog2(BEKLEME_SINIR + 1);
    localparam logic [SW-1:0] SINIR = SW'(BEKLEME_SINIR);
    localparam logic [SW-1:0] SON   = SW'(BEKLEME_SINIR - 1);

    kd_durum_t     r_durum;
    kd_durum_t     w_sonraki;
    logic [SW-1:0] r_sayac;
    logic [31:0]   r_neden;
    logic [31:0]   r_kod_son;
    logic [31:0]   r_ps_son;
    logic          w_kesme;
    logic [31:0]   w_mip;
    logic [2:0]    w_uygun;
    logic          w_var;
    logic [31:0]   w_neden;
    logic          w_unused_mie;

`ifdef KESME_ESZAMANLAYICI_EN
    logic r_senk1;
    logic r_senk2;

    // Two-flop synchronizer for the asynchronous external interrupt line.
    always_ff @(posedge clk_g or posedge rst_g) begin
        if (rst_g) begin
            r_senk1 <= 1'b0;
            r_senk2 <= 1'b0;
        end else begin
            r_senk1 <= kesme_g;
            r_senk2 <= r_senk1;
        end
    end

    assign w_kesme = r_senk2;
`else
    assign w_kesme = kesme_g;
`endif

    // Live pending bits, also exported for mip reads.
    always_comb begin
        w_mip          = '0;
        w_mip[MIP_MEI] = w_kesme;
        w_mip[MIP_MSI] = yazilim_kesme_g;
        w_mip[MIP_MTI] = zamanlayici_kesme_g;
    end

    assign mip_c   = w_mip;
    assign w_uygun = {w_mip[MIP_MEI] & mie_g[MIP_MEI],
                      w_mip[MIP_MSI] & mie_g[MIP_MSI],
                      w_mip[MIP_MTI] & mie_g[MIP_MTI]} & {3{mstatus_mie_g}};
    assign w_unused_mie = ^{mie_g[31:12], mie_g[10:8], mie_g[6:4], mie_g[2:0]};

    kesme_oncelik_secici u_oncelik (
        .i_uygun (w_uygun),
        .o_var   (w_var),
        .o_neden (w_neden)
    );

    // State register; async reset drops the stall immediately.
    always_ff @(posedge clk_g or posedge rst_g) begin
        if (rst_g) r_durum <= KD_BOSTA;
        else       r_durum <= w_sonraki;
    end

    // Next state and per-state control outputs.
    always_comb begin
        w_sonraki       = r_durum;
        getir_durdur_c  = 1'b0;
        kesme_gecerli_c = 1'b0;
        zaman_asimi_c   = 1'b0;
        case (r_durum)
            KD_BOSTA: begin
                if (w_var && !odd_mesgul_g) w_sonraki = KD_BEKLE;
            end
            KD_BEKLE: begin
                getir_durdur_c = 1'b1;
                zaman_asimi_c  = (r_sayac == SON);
                if (boru_bos_g && !odd_mesgul_g) w_sonraki = KD_TETIKLE;
            end
            KD_TETIKLE: begin
                getir_durdur_c  = 1'b1;
                kesme_gecerli_c = 1'b1;
                w_sonraki       = KD_ISLE;
            end
            KD_ISLE: begin
                if (mret_g) w_sonraki = KD_BOSTA;
            end
            default: w_sonraki = KD_BOSTA;
        endcase
    end

    // Drain counter, latched cause and the held trap outputs.
    always_ff @(posedge clk_g or posedge rst_g) begin
        if (rst_g) begin
            r_sayac   <= '0;
            r_neden   <= '0;
            r_kod_son <= '0;
            r_ps_son  <= '0;
        end else begin
            if (r_durum == KD_BEKLE) begin
                if (r_sayac != SINIR) r_sayac <= r_sayac + SW'(1);
            end else begin
                r_sayac <= '0;
            end

            if (r_durum == KD_BOSTA && w_sonraki == KD_BEKLE) begin
                r_neden <= w_neden;
            end else if (r_durum == KD_BEKLE && w_var &&
                         neden_derece(w_neden) > neden_derece(r_neden)) begin
                r_neden <= w_neden;
            end

            if (r_durum == KD_TETIKLE) begin
                r_kod_son <= r_neden;
                r_ps_son  <= siradaki_ps_g;
            end
        end
    end

    // Trap PC is taken live in the trap cycle and held afterwards.
    assign kesme_kod_c = (r_durum == KD_TETIKLE) ? r_neden       : r_kod_son;
    assign kesme_ps_c  = (r_durum == KD_TETIKLE) ? siradaki_ps_g : r_ps_son;

endmodule

// File: tb/tb_kesme_denetleyici.sv
// Self-checking bench for kesme_denetleyici: directed scenarios followed by
// random stimulus, every cycle compared against a behavioural model.
module tb_kesme_denetleyici;

    localparam int unsigned SINIR = 8;
`ifdef KESME_ESZAMANLAYICI_EN
    localparam int EK = 2;
`else
    localparam int EK = 0;
`endif
    localparam logic [31:0] C_MEI = 32'h8000_000B;
    localparam logic [31:0] C_MSI = 32'h8000_0003;
    localparam logic [31:0] C_MTI = 32'h8000_0007;

    logic        clk_g = 1'b0;
    logic        rst_g;
    logic        kesme_g, yazilim_kesme_g, zamanlayici_kesme_g, mstatus_mie_g;
    logic [31:0] mie_g;
    logic        boru_bos_g, odd_mesgul_g, mret_g;
    logic [31:0] siradaki_ps_g;
    logic        getir_durdur_c, kesme_gecerli_c, zaman_asimi_c;
    logic [31:0] kesme_kod_c, kesme_ps_c, mip_c;

    always #5 clk_g = ~clk_g;

    kesme_denetleyici #(.BEKLEME_SINIR(SINIR)) dut (
        .clk_g               (clk_g),
        .rst_g               (rst_g),
        .kesme_g             (kesme_g),
        .yazilim_kesme_g     (yazilim_kesme_g),
        .zamanlayici_kesme_g (zamanlayici_kesme_g),
        .mstatus_mie_g       (mstatus_mie_g),
        .mie_g               (mie_g),
        .boru_bos_g          (boru_bos_g),
        .odd_mesgul_g        (odd_mesgul_g),
        .mret_g              (mret_g),
        .siradaki_ps_g       (siradaki_ps_g),
        .getir_durdur_c      (getir_durdur_c),
        .kesme_gecerli_c     (kesme_gecerli_c),
        .kesme_kod_c         (kesme_kod_c),
        .kesme_ps_c          (kesme_ps_c),
        .mip_c               (mip_c),
        .zaman_asimi_c       (zaman_asimi_c)
    );

    int hata = 0, toplam = 0, dongu = 0;
    int trap_sayisi = 0, son_trap_dongu = -1, zaman_sayisi = 0, son_zaman_dongu = -1;
    logic [31:0] son_kod = '0, son_ps = '0;

    // Behavioural reference: waiting for drain, trap cycle, servicing.
    bit          m_bek, m_tet, m_isle;
    int          m_sure;
    logic [31:0] m_neden, m_kod, m_ps;
    logic        m_s1, m_s2;

    function automatic logic [31:0] m_kazanan(input logic [2:0] u);
        if (u[2])      return C_MEI;
        else if (u[1]) return C_MSI;
        else if (u[0]) return C_MTI;
        return '0;
    endfunction

    function automatic int m_derece(input logic [31:0] c);
        if (c == C_MEI) return 3;
        if (c == C_MSI) return 2;
        if (c == C_MTI) return 1;
        return 0;
    endfunction

    task automatic kontrol(input string tag, input logic [31:0] g, input logic [31:0] b);
        toplam++;
        assert (g === b) else begin
            hata++;
            $error("FAIL %s observed=%h expected=%h", tag, g, b);
        end
    endtask

    task automatic m_sifirla();
        m_bek = 0; m_tet = 0; m_isle = 0; m_sure = 0;
        m_neden = '0; m_kod = '0; m_ps = '0; m_s1 = 0; m_s2 = 0;
    endtask

    task automatic adim();
        logic        ext;
        logic [2:0]  u;
        logic [31:0] w, mip;
        @(negedge clk_g);
`ifdef KESME_ESZAMANLAYICI_EN
        ext = m_s2;
`else
        ext = kesme_g;
`endif
        mip = '0; mip[11] = ext; mip[3] = yazilim_kesme_g; mip[7] = zamanlayici_kesme_g;
        u = {ext & mie_g[11], yazilim_kesme_g & mie_g[3], zamanlayici_kesme_g & mie_g[7]}
            & {3{mstatus_mie_g}};
        w = m_kazanan(u);
        kontrol("getir_durdur", 32'(getir_durdur_c), 32'(m_bek || m_tet));
        kontrol("kesme_gecerli", 32'(kesme_gecerli_c), 32'(m_tet));
        kontrol("kesme_kod", kesme_kod_c, m_tet ? m_neden : m_kod);
        kontrol("kesme_ps", kesme_ps_c, m_tet ? siradaki_ps_g : m_ps);
        kontrol("zaman_asimi", 32'(zaman_asimi_c), 32'(m_bek && m_sure == int'(SINIR) - 1));
        kontrol("mip", mip_c, mip);
        if (kesme_gecerli_c === 1'b1) begin
            trap_sayisi++; son_trap_dongu = dongu; son_kod = kesme_kod_c; son_ps = kesme_ps_c;
        end
        if (zaman_asimi_c === 1'b1) begin
            zaman_sayisi++; son_zaman_dongu = dongu;
        end
        @(posedge clk_g);
        if (rst_g) begin
            m_sifirla();
        end else begin
            if (m_tet) begin
                m_kod = m_neden; m_ps = siradaki_ps_g; m_tet = 0; m_isle = 1;
            end else if (m_isle) begin
                if (mret_g) m_isle = 0;
            end else if (m_bek) begin
                if (u != 0 && m_derece(w) > m_derece(m_neden)) m_neden = w;
                m_sure++;
                if (boru_bos_g && !odd_mesgul_g) begin m_bek = 0; m_tet = 1; end
            end else if (u != 0 && !odd_mesgul_g) begin
                m_bek = 1; m_sure = 0; m_neden = w;
            end
            m_s2 = m_s1; m_s1 = kesme_g;
        end
        #1;
        dongu++;
    endtask

    // Drop all sources, let any pending trap complete, then return via MRET.
    task automatic temizle();
        kesme_g = 0; yazilim_kesme_g = 0; zamanlayici_kesme_g = 0;
        boru_bos_g = 1; odd_mesgul_g = 0; mret_g = 0;
        repeat (3) adim();
        mret_g = 1; adim();
        mret_g = 0; repeat (2) adim();
    endtask

    int tr0, z0, e, t, m;

    initial begin
        rst_g = 1; kesme_g = 0; yazilim_kesme_g = 0; zamanlayici_kesme_g = 0;
        mstatus_mie_g = 0; mie_g = '0; boru_bos_g = 0; odd_mesgul_g = 0;
        mret_g = 0; siradaki_ps_g = '0;
        m_sifirla();
        repeat (2) adim();
        rst_g = 0;
        dongu = 0;

        // External interrupt, drained pipeline, fixed latency.
        mstatus_mie_g = 1; mie_g = 32'h800; boru_bos_g = 1; siradaki_ps_g = 32'h400;
        repeat (10) adim();
        kesme_g = 1;
        repeat (4 + EK) adim();
        kontrol("t1_gecikme", 32'(son_trap_dongu), 32'(12 + EK));
        kontrol("t1_kod", son_kod, C_MEI);
        kontrol("t1_ps", son_ps, 32'h400);
        kontrol("t1_mip", mip_c, 32'h800);
        temizle();

        // All three sources together: external wins, then software.
        mie_g = 32'h888; mstatus_mie_g = 0; kesme_g = 1;
        repeat (3) adim();
        yazilim_kesme_g = 1; zamanlayici_kesme_g = 1; mstatus_mie_g = 1;
        repeat (4) adim();
        kontrol("t2_ext_kod", son_kod, C_MEI);
        temizle();
        yazilim_kesme_g = 1; zamanlayici_kesme_g = 1;
        repeat (4) adim();
        kontrol("t2_sw_kod", son_kod, C_MSI);
        temizle();

        // Pipeline busy for five cycles after entering the wait.
        mie_g = 32'h008; yazilim_kesme_g = 1; boru_bos_g = 0;
        adim();
        repeat (5) adim();
        boru_bos_g = 1; t = dongu;
        repeat (2) adim();
        kontrol("t3_bosalma_sonrasi", 32'(son_trap_dongu), 32'(t + 1));
        temizle();

        // Drain timeout: one pulse on the eighth wait cycle, no trap.
        z0 = zaman_sayisi; tr0 = trap_sayisi;
        mie_g = 32'h008; yazilim_kesme_g = 1; boru_bos_g = 0; e = dongu;
        repeat (14) adim();
        kontrol("t4_darbe_sayisi", 32'(zaman_sayisi - z0), 32'd1);
        kontrol("t4_darbe_zamani", 32'(son_zaman_dongu), 32'(e + 8));
        kontrol("t4_trap_yok", 32'(trap_sayisi - tr0), 32'd0);
        temizle();

        // Pending timer held off until MRET, then retaken.
        mie_g = 32'h080; zamanlayici_kesme_g = 1; boru_bos_g = 1;
        repeat (3) adim();
        tr0 = trap_sayisi;
        repeat (6) adim();
        kontrol("t5_mret_oncesi", 32'(trap_sayisi - tr0), 32'd0);
        mret_g = 1; m = dongu; adim();
        mret_g = 0; repeat (4) adim();
        kontrol("t5_yeni_trap", 32'(son_trap_dongu), 32'(m + 3));
        kontrol("t5_kod", son_kod, C_MTI);
        temizle();

        // Asynchronous reset while waiting for drain.
        mie_g = 32'h800; mstatus_mie_g = 1; kesme_g = 1; boru_bos_g = 0;
        repeat (2 + EK) adim();
        kontrol("t6_durdur_once", 32'(getir_durdur_c), 32'd1);
        #2 rst_g = 1;
        #1 kontrol("t6_durdur_birakildi", 32'(getir_durdur_c), 32'd0);
        m_sifirla();
        kesme_g = 0; mstatus_mie_g = 0; tr0 = trap_sayisi;
        repeat (2) adim();
        rst_g = 0;
        repeat (5) adim();
        kontrol("t6_trap_yok", 32'(trap_sayisi - tr0), 32'd0);

        // Random traffic against the model.
        for (int i = 0; i < 400; i++) begin
            kesme_g             = ($urandom_range(0, 2) == 0);
            yazilim_kesme_g     = ($urandom_range(0, 3) == 0);
            zamanlayici_kesme_g = ($urandom_range(0, 3) == 0);
            mstatus_mie_g       = ($urandom_range(0, 4) != 0);
            mie_g               = $urandom;
            boru_bos_g          = ($urandom_range(0, 3) != 0);
            odd_mesgul_g        = ($urandom_range(0, 9) == 0);
            mret_g              = ($urandom_range(0, 4) == 0);
            siradaki_ps_g       = $urandom;
            adim();
        end

        $display("Result: errors=%0d of %0d checks", hata, toplam);
        $finish;
    end

endmodule
